rv32i_mc_ctrl: RTL and testbench
================================

RV32I_MC_CTRL -- requirements
Module: rv32i_mc_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, 16, max consecutive memory-stall cycles before timeout trap (range 1..255).
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: opcode  in  7  instruction-register bits [6:0].
REQ-005 SHALL have port: mem_ready  in  1  shared memory completed current request this cycle.
REQ-006 SHALL have port: branch_taken  in  1  ALU branch-condition result, valid in EXEC.
REQ-007 SHALL have outputs, all 1 bit: mem_req (request to shared memory), mem_we (write), mem_addr_sel (0=PC, 1=ALU result), ir_we (load instruction register), pc_we (update PC), reg_we (register-file write).
REQ-008 SHALL have outputs, all 2 bits: pc_src (0=PC+4, 1=PC-relative target, 2=JALR target), alu_src_a (0=rs1, 1=old PC, 2=zero), wb_sel (0=ALU, 1=mem data, 2=PC+4).
REQ-009 SHALL have outputs: alu_src_b  out  1  (0=rs2, 1=immediate); state  out  3  current state; trap  out  1  sticky trap flag; trap_cause  out  2  (0=none, 1=illegal opcode, 2=memory timeout, 3=ECALL/EBREAK); instret  out  32  retired-instruction count.

Function
REQ-010 SHALL implement Moore FSM FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all control outputs decode from state, latched opcode class and branch_taken only.
REQ-011 FETCH SHALL assert mem_req with mem_addr_sel=0 and hold until mem_ready; in the mem_ready cycle, ir_we=1, pc_we=1, pc_src=0, next state DECODE.
REQ-012 DECODE SHALL last one cycle; opcode not in {3,15,19,23,35,51,55,99,103,111,115} -> TRAP with cause 1; 115 -> TRAP with cause 3; otherwise -> EXEC.
REQ-013 EXEC SHALL last one cycle and drive ALU selects per class: OP (51) a=0,b=0; OP-IMM (19) / LOAD (3) / STORE (35) / JALR (103) a=0,b=1; LUI (55) a=2,b=1; AUIPC (23) / JAL (111) / BRANCH (99) a=1,b=1.
REQ-014 EXEC exits: LOAD/STORE -> MEM; OP/OP-IMM/LUI/AUIPC -> WB; JAL -> WB with pc_we=1, pc_src=1; JALR -> WB with pc_we=1, pc_src=2; BRANCH -> FETCH, pc_we=branch_taken, pc_src=1; FENCE (15) -> FETCH as NOP.
REQ-015 MEM SHALL assert mem_req, mem_addr_sel=1, mem_we=1 for STORE only; hold until mem_ready; then LOAD -> WB, STORE -> FETCH.
REQ-016 WB SHALL last one cycle with reg_we=1; wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise; next state FETCH.
REQ-017 instret SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, and wrap from 0xFFFFFFFF to 0.
REQ-018 8-bit stall counter SHALL increment each FETCH/MEM cycle with mem_req=1 and mem_ready=0, and clear on mem_ready or state change; stall count reaching WAIT_LIMIT without mem_ready -> TRAP with cause 2 at next edge; mem_ready in that same cycle takes priority (no trap).
REQ-019 TRAP SHALL be absorbing until rst: all enables (mem_req, mem_we, ir_we, pc_we, reg_we) 0, trap=1, trap_cause held, instret frozen.
REQ-020 mem_we SHALL never be 1 while mem_req=0; at most one of ir_we and reg_we SHALL be 1 in any cycle.

Reset
REQ-021 rst SHALL override all other inputs: next state FETCH; instret, stall counter, trap, trap_cause and latched opcode class cleared; all selects 0.
REQ-022 rst asserted mid-access SHALL drop mem_req in the following cycle and restart at FETCH with no partial retire or register write.

Structure
REQ-023 Opcode constants, state encodings and select encodings SHALL reside in a shared include file also used by the datapath and immediate generator.
REQ-024 Opcode-class decode SHALL be one combinational sub-module, rv32i_opclass, instantiated once; FSM, counters and output decode SHALL reside in rv32i_mc_ctrl.

Verification
REQ-025 ADDI (opcode 19), mem_ready=1 in the first FETCH cycle -> states 0,1,2,4,0; reg_we high exactly one cycle; instret 0->1.
REQ-026 LW with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_addr_sel 0 then 1; wb_sel=1 in WB; instret +1.
REQ-027 BEQ with branch_taken=1, then branch_taken=0 -> pc_we=1, pc_src=1 in EXEC only for the first; neither case asserts reg_we.
REQ-028 WAIT_LIMIT=4, mem_ready held 0 in FETCH -> TRAP entered after 4 stall cycles, trap_cause=2, mem_req=0 thereafter.
REQ-029 opcode 7'h7F -> TRAP cause 1; opcode 115 -> TRAP cause 3; rst pulse -> FETCH, trap=0, instret=0.
REQ-030 rst asserted during a stalled SW in MEM -> mem_we and mem_req low the next cycle, state=0, instret unchanged (0).

Source files
------------

// File: rtl/rv32i_mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds the opcode constants, FSM state encoding, opcode-class encoding and
// the datapath select encodings. The datapath and immediate generator import
// this same package so that every block agrees on the encodings.
package rv32i_mc_ctrl_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_FENCE  = 7'd15;
  localparam logic [6:0] OPC_OP_IMM = 7'd19;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_SYSTEM = 7'd115;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Opcode classes; CLS_ILLEGAL is also the cleared value after reset
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_FENCE   = 4'd2,
    CLS_OP_IMM  = 4'd3,
    CLS_AUIPC   = 4'd4,
    CLS_STORE   = 4'd5,
    CLS_OP      = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_BRANCH  = 4'd8,
    CLS_JALR    = 4'd9,
    CLS_JAL     = 4'd10,
    CLS_SYSTEM  = 4'd11
  } opclass_e;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4 = 2'd0,
    PC_SRC_REL   = 2'd1,
    PC_SRC_JALR  = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_e;

  typedef enum logic {
    ALU_B_RS2 = 1'b0,
    ALU_B_IMM = 1'b1
  } alu_b_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_ENV     = 2'd3
  } trap_cause_e;

  // Register-file write source for a class that reaches WB
  function automatic wb_sel_e wb_sel_for(opclass_e cls);
    case (cls)
      CLS_LOAD:          return WB_MEM;
      CLS_JAL, CLS_JALR: return WB_PC4;
      default:           return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mc_ctrl_if.sv
// Shared-memory handshake between the control FSM and the memory port.
//   mem_req      : request to shared memory
//   mem_we       : request is a write
//   mem_addr_sel : address source, 0 = PC, 1 = ALU result
//   mem_ready    : memory completed the current request this cycle
// master = controller side, slave = memory side.
interface rv32i_mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/rv32i_opclass.sv
// Combinational opcode-class decoder.
//   opcode  in  7  instruction bits [6:0]
//   opclass out    class of the instruction; CLS_ILLEGAL for unsupported opcodes
module rv32i_opclass
  import rv32i_mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   opclass
);

  always_comb begin
    opclass = CLS_ILLEGAL;
    case (opcode)
      OPC_LOAD:   opclass = CLS_LOAD;
      OPC_FENCE:  opclass = CLS_FENCE;
      OPC_OP_IMM: opclass = CLS_OP_IMM;
      OPC_AUIPC:  opclass = CLS_AUIPC;
      OPC_STORE:  opclass = CLS_STORE;
      OPC_OP:     opclass = CLS_OP;
      OPC_LUI:    opclass = CLS_LUI;
      OPC_BRANCH: opclass = CLS_BRANCH;
      OPC_JALR:   opclass = CLS_JALR;
      OPC_JAL:    opclass = CLS_JAL;
      OPC_SYSTEM: opclass = CLS_SYSTEM;
      default:    opclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB FSM with a TRAP
// state, memory-stall timeout and retired-instruction counter.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   mem           : shared-memory handshake (master side)
//   opcode        : instruction-register bits [6:0]
//   branch_taken  : ALU branch condition, meaningful in EXEC
//   ir_we, pc_we, reg_we          : IR / PC / register-file write enables
//   pc_src, alu_src_a, alu_src_b, wb_sel : datapath selects
//   state         : current FSM state
//   trap, trap_cause : sticky trap flag and its cause
//   instret       : retired-instruction count (wraps)
// WAIT_LIMIT (1..255) is the number of consecutive stalled memory cycles
// tolerated; the last allowed stall cycle without mem_ready sends the FSM to
// TRAP on the following edge.
module rv32i_mc_ctrl
  import rv32i_mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32i_mc_ctrl_if.master        mem,
  input  logic [6:0]             opcode,
  input  logic                   branch_taken,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic                   reg_we,
  output logic [1:0]             pc_src,
  output logic [1:0]             alu_src_a,
  output logic                   alu_src_b,
  output logic [1:0]             wb_sel,
  output logic [2:0]             state,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [31:0]            instret
);

  localparam logic [7:0] WAIT_LIMIT_U8 = 8'(WAIT_LIMIT);

  state_e      state_reg;
  opclass_e    opclass_reg;
  logic [7:0]  stall_cnt_reg;
  logic [31:0] instret_reg;
  logic        trap_reg;
  trap_cause_e trap_cause_reg;

  opclass_e    opclass;
  logic        stall_cycle;
  logic        stall_hit;

  pc_src_e     pc_src_sel;
  alu_a_e      alu_a_sel;
  alu_b_e      alu_b_sel;
  wb_sel_e     wb_sel_val;

  rv32i_opclass u_opclass (
    .opcode  (opcode),
    .opclass (opclass)
  );

  // A stall is a cycle in which the FSM is requesting memory and the memory
  // has not answered. stall_hit marks the last tolerated stall cycle, so the
  // count of stall cycles spent before TRAP equals WAIT_LIMIT exactly.
  assign stall_cycle = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem.mem_ready;
  assign stall_hit   = stall_cycle && ((stall_cnt_reg + 8'd1) >= WAIT_LIMIT_U8);

  // ---------------------------------------------------------------------
  // FSM, stall counter, retire counter and trap bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_FETCH;
      opclass_reg    <= CLS_ILLEGAL;
      stall_cnt_reg  <= 8'd0;
      instret_reg    <= 32'd0;
      trap_reg       <= 1'b0;
      trap_cause_reg <= CAUSE_NONE;
    end else begin
      // Counter clears on mem_ready, on leaving the state, and outside
      // FETCH/MEM; a timeout also leaves the state, so it clears too.
      stall_cnt_reg <= (stall_cycle && !stall_hit) ? stall_cnt_reg + 8'd1 : 8'd0;

      case (state_reg)
        ST_FETCH: begin
          if (mem.mem_ready) begin
            state_reg <= ST_DECODE;
          end else if (stall_hit) begin
            state_reg      <= ST_TRAP;
            trap_reg       <= 1'b1;
            trap_cause_reg <= CAUSE_TIMEOUT;
          end
        end

        ST_DECODE: begin
          // IR was loaded at the end of FETCH, so opcode is valid here.
          opclass_reg <= opclass;
          case (opclass)
            CLS_ILLEGAL: begin
              state_reg      <= ST_TRAP;
              trap_reg       <= 1'b1;
              trap_cause_reg <= CAUSE_ILLEGAL;
            end
            CLS_SYSTEM: begin
              state_reg      <= ST_TRAP;
              trap_reg       <= 1'b1;
              trap_cause_reg <= CAUSE_ENV;
            end
            default: state_reg <= ST_EXEC;
          endcase
        end

        ST_EXEC: begin
          case (opclass_reg)
            CLS_LOAD, CLS_STORE: state_reg <= ST_MEM;
            CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR:
              state_reg <= ST_WB;
            default: begin
              // BRANCH and FENCE complete in EXEC.
              state_reg   <= ST_FETCH;
              instret_reg <= instret_reg + 32'd1;
            end
          endcase
        end

        ST_MEM: begin
          if (mem.mem_ready) begin
            if (opclass_reg == CLS_LOAD) begin
              state_reg <= ST_WB;
            end else begin
              state_reg   <= ST_FETCH;
              instret_reg <= instret_reg + 32'd1;
            end
          end else if (stall_hit) begin
            state_reg      <= ST_TRAP;
            trap_reg       <= 1'b1;
            trap_cause_reg <= CAUSE_TIMEOUT;
          end
        end

        ST_WB: begin
          state_reg   <= ST_FETCH;
          instret_reg <= instret_reg + 32'd1;
        end

        ST_TRAP: state_reg <= ST_TRAP;

        default: state_reg <= ST_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output decode from state, latched class and branch_taken. While rst is
  // asserted every enable and select is forced to 0 so an access in flight
  // is dropped immediately and stays dropped for as long as reset is held.
  // FETCH qualifies ir_we/pc_we with mem_ready so a stalled fetch does not
  // advance the PC.
  // ---------------------------------------------------------------------
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    reg_we           = 1'b0;
    pc_src_sel       = PC_SRC_PLUS4;
    alu_a_sel        = ALU_A_RS1;
    alu_b_sel        = ALU_B_RS2;
    wb_sel_val       = WB_ALU;

    if (!rst) begin
      case (state_reg)
        ST_FETCH: begin
          mem.mem_req = 1'b1;
          ir_we       = mem.mem_ready;
          pc_we       = mem.mem_ready;
        end

        ST_EXEC: begin
          case (opclass_reg)
            CLS_OP_IMM, CLS_LOAD, CLS_STORE: alu_b_sel = ALU_B_IMM;
            CLS_JALR: begin
              alu_b_sel  = ALU_B_IMM;
              pc_we      = 1'b1;
              pc_src_sel = PC_SRC_JALR;
            end
            CLS_LUI: begin
              alu_a_sel = ALU_A_ZERO;
              alu_b_sel = ALU_B_IMM;
            end
            CLS_AUIPC: begin
              alu_a_sel = ALU_A_PC;
              alu_b_sel = ALU_B_IMM;
            end
            CLS_JAL: begin
              alu_a_sel  = ALU_A_PC;
              alu_b_sel  = ALU_B_IMM;
              pc_we      = 1'b1;
              pc_src_sel = PC_SRC_REL;
            end
            CLS_BRANCH: begin
              alu_a_sel  = ALU_A_PC;
              alu_b_sel  = ALU_B_IMM;
              pc_we      = branch_taken;
              pc_src_sel = PC_SRC_REL;
            end
            default: begin
              // OP uses rs1/rs2; FENCE does nothing.
              alu_a_sel = ALU_A_RS1;
            end
          endcase
        end

        ST_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (opclass_reg == CLS_STORE);
        end

        ST_WB: begin
          reg_we     = 1'b1;
          wb_sel_val = wb_sel_for(opclass_reg);
        end

        default: begin
          // DECODE and TRAP drive nothing.
          reg_we = 1'b0;
        end
      endcase
    end
  end

  assign pc_src     = pc_src_sel;
  assign alu_src_a  = alu_a_sel;
  assign alu_src_b  = alu_b_sel;
  assign wb_sel     = wb_sel_val;
  assign state      = state_reg;
  assign trap       = trap_reg;
  assign trap_cause = trap_cause_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Self-checking bench for rv32i_mc_ctrl (WAIT_LIMIT = 4).
// Each scenario queues per-cycle stimulus together with the expected output
// vector, then drains the queue: inputs change on the falling edge, outputs
// are sampled 1 ns later and compared against the queued expectation.
module tb_rv32i_mc_ctrl;

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic        reg_we;
    logic [1:0]  pc_src;
    logic [1:0]  alu_a;
    logic        alu_b;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] instret;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       bt;
    logic [6:0] opc;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        branch_taken = 1'b0;
  logic        ir_we, pc_we, reg_we, alu_src_b, trap;
  logic [1:0]  pc_src, alu_src_a, wb_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  rv32i_mc_ctrl_if mem_bus ();

  rv32i_mc_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mem_bus),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .reg_we       (reg_we),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .wb_sel       (wb_sel),
    .state        (state),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  stim_t stim_q[$];
  outs_t exp_q[$];
  int    compared = 0;
  int    mismatched = 0;
  int    exp_ir = 0;

  // ---- expected-vector builders ----
  function automatic outs_t o_quiet(logic [2:0] st, int ir);
    outs_t o;
    o = '0;
    o.state = st;
    o.instret = 32'(ir);
    return o;
  endfunction

  function automatic outs_t o_fetch(logic rdy, int ir);
    outs_t o;
    o = o_quiet(3'd0, ir);
    o.mem_req = 1'b1;
    o.ir_we = rdy;
    o.pc_we = rdy;
    return o;
  endfunction

  function automatic outs_t o_exec(logic [1:0] a, logic b, logic pw, logic [1:0] ps, int ir);
    outs_t o;
    o = o_quiet(3'd2, ir);
    o.alu_a = a;
    o.alu_b = b;
    o.pc_we = pw;
    o.pc_src = ps;
    return o;
  endfunction

  function automatic outs_t o_mem(logic we, int ir);
    outs_t o;
    o = o_quiet(3'd3, ir);
    o.mem_req = 1'b1;
    o.mem_addr_sel = 1'b1;
    o.mem_we = we;
    return o;
  endfunction

  function automatic outs_t o_wb(logic [1:0] ws, int ir);
    outs_t o;
    o = o_quiet(3'd4, ir);
    o.reg_we = 1'b1;
    o.wb_sel = ws;
    return o;
  endfunction

  function automatic outs_t o_trap(logic [1:0] c, int ir);
    outs_t o;
    o = o_quiet(3'd5, ir);
    o.trap = 1'b1;
    o.cause = c;
    return o;
  endfunction

  task automatic push(input logic r, input logic rdy, input logic bt,
                      input logic [6:0] opc, input outs_t e);
    stim_t s;
    s.rst = r;
    s.rdy = rdy;
    s.bt = bt;
    s.opc = opc;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Applies the next queued stimulus and samples the DUT outputs.
  task automatic step(output outs_t obs);
    stim_t s;
    s = stim_q.pop_front();
    @(negedge clk);
    rst = s.rst;
    mem_bus.mem_ready = s.rdy;
    branch_taken = s.bt;
    opcode = s.opc;
    #1;
    obs = '0;
    obs.state = state;
    obs.mem_req = mem_bus.mem_req;
    obs.mem_we = mem_bus.mem_we;
    obs.mem_addr_sel = mem_bus.mem_addr_sel;
    obs.ir_we = ir_we;
    obs.pc_we = pc_we;
    obs.reg_we = reg_we;
    obs.pc_src = pc_src;
    obs.alu_a = alu_src_a;
    obs.alu_b = alu_src_b;
    obs.wb_sel = wb_sel;
    obs.trap = trap;
    obs.cause = trap_cause;
    obs.instret = instret;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    outs_t obs, want;
    int n = 0;
    push(1'b1, 1'b0, 1'b0, 7'd0, o_quiet(3'd0, 0));
    push(1'b1, 1'b1, 1'b1, 7'd19, o_quiet(3'd0, 0));
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL reset cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
    $display("reset: held, state=%0d instret=%0d", state, instret);
  endtask

  task automatic test_addi();
    outs_t obs, want;
    int n = 0;
    push(1'b0, 1'b1, 1'b0, 7'd19, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd19, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd19, o_exec(2'd0, 1'b1, 1'b0, 2'd0, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd19, o_wb(2'd0, exp_ir));
    exp_ir++;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL addi cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
    $display("addi: done, expect instret=%0d", exp_ir);
  endtask

  // LW with three stall cycles in both FETCH and MEM (one short of the limit);
  // the first FETCH cycle also confirms the previous retire.
  task automatic test_load();
    outs_t obs, want;
    int n = 0;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 7'd3, o_fetch(1'b0, exp_ir));
    push(1'b0, 1'b1, 1'b0, 7'd3, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd3, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd3, o_exec(2'd0, 1'b1, 1'b0, 2'd0, exp_ir));
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 7'd3, o_mem(1'b0, exp_ir));
    push(1'b0, 1'b1, 1'b0, 7'd3, o_mem(1'b0, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd3, o_wb(2'd1, exp_ir));
    exp_ir++;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL load cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
    $display("lw: done, expect instret=%0d", exp_ir);
  endtask

  task automatic test_branch();
    outs_t obs, want;
    int n = 0;
    // taken
    push(1'b0, 1'b1, 1'b0, 7'd99, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd99, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b0, 1'b1, 7'd99, o_exec(2'd1, 1'b1, 1'b1, 2'd1, exp_ir));
    exp_ir++;
    // not taken; branch_taken high in DECODE must have no effect
    push(1'b0, 1'b1, 1'b0, 7'd99, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b1, 7'd99, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd99, o_exec(2'd1, 1'b1, 1'b0, 2'd1, exp_ir));
    exp_ir++;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL branch cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
    $display("beq: taken and not-taken done, expect instret=%0d", exp_ir);
  endtask

  // Every remaining legal class, issued back to back.
  task automatic test_back_to_back();
    outs_t obs, want;
    int n = 0;
    int ops[8] = '{51, 19, 55, 23, 111, 103, 15, 35};
    logic [6:0] opc;
    logic [1:0] a, ps, ws;
    logic b, pw;
    int kind;   // 0 = via WB, 1 = ends in EXEC, 2 = store via MEM
    for (int i = 0; i < 8; i++) begin
      opc = 7'(ops[i]);
      a = 2'd0; b = 1'b0; pw = 1'b0; ps = 2'd0; ws = 2'd0; kind = 0;
      case (ops[i])
        19:  b = 1'b1;
        55:  begin a = 2'd2; b = 1'b1; end
        23:  begin a = 2'd1; b = 1'b1; end
        111: begin a = 2'd1; b = 1'b1; pw = 1'b1; ps = 2'd1; ws = 2'd2; end
        103: begin b = 1'b1; pw = 1'b1; ps = 2'd2; ws = 2'd2; end
        15:  kind = 1;
        35:  begin b = 1'b1; kind = 2; end
        default: kind = 0;
      endcase
      push(1'b0, 1'b1, 1'b0, opc, o_fetch(1'b1, exp_ir));
      push(1'b0, 1'b0, 1'b0, opc, o_quiet(3'd1, exp_ir));
      push(1'b0, 1'b0, 1'b0, opc, o_exec(a, b, pw, ps, exp_ir));
      if (kind == 0) push(1'b0, 1'b0, 1'b0, opc, o_wb(ws, exp_ir));
      if (kind == 2) push(1'b0, 1'b1, 1'b0, opc, o_mem(1'b1, exp_ir));
      exp_ir++;
      $display("b2b: opcode %0d queued, expect instret=%0d after", ops[i], exp_ir);
    end
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL b2b cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
  endtask

  // Illegal opcode and ECALL traps, each cleared by a one-cycle rst pulse.
  task automatic test_decode_traps();
    outs_t obs, want;
    int n = 0;
    push(1'b0, 1'b1, 1'b0, 7'h7F, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'h7F, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b1, 1'b1, 7'h7F, o_trap(2'd1, exp_ir));
    push(1'b0, 1'b1, 1'b0, 7'd19, o_trap(2'd1, exp_ir));
    push(1'b1, 1'b1, 1'b0, 7'd19, o_trap(2'd1, exp_ir));
    exp_ir = 0;
    push(1'b0, 1'b0, 1'b0, 7'd115, o_fetch(1'b0, exp_ir));
    push(1'b0, 1'b1, 1'b0, 7'd115, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd115, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b1, 1'b0, 7'd115, o_trap(2'd3, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd115, o_trap(2'd3, exp_ir));
    push(1'b1, 1'b0, 1'b0, 7'd0, o_trap(2'd3, exp_ir));
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL dtrap cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
    $display("traps: illegal and ecall done, expect instret=%0d", exp_ir);
  endtask

  // Exactly WAIT_LIMIT (4) stalled FETCH cycles, then TRAP with cause 2.
  task automatic test_timeout();
    outs_t obs, want;
    int n = 0;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, 7'd19, o_fetch(1'b0, exp_ir));
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b0, 7'd19, o_trap(2'd2, exp_ir));
    push(1'b1, 1'b0, 1'b0, 7'd0, o_trap(2'd2, exp_ir));
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL timeout cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
    $display("timeout: trap after 4 stalls, instret=%0d", exp_ir);
  endtask

  // Reset during a stalled SW in MEM, then an ADDI to show clean restart.
  task automatic test_reset_mid_access();
    outs_t obs, want;
    int n = 0;
    push(1'b0, 1'b1, 1'b0, 7'd35, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd35, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd35, o_exec(2'd0, 1'b1, 1'b0, 2'd0, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd35, o_mem(1'b1, exp_ir));
    push(1'b1, 1'b0, 1'b0, 7'd35, o_quiet(3'd3, exp_ir));
    push(1'b1, 1'b0, 1'b0, 7'd35, o_quiet(3'd0, exp_ir));
    push(1'b0, 1'b1, 1'b0, 7'd19, o_fetch(1'b1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd19, o_quiet(3'd1, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd19, o_exec(2'd0, 1'b1, 1'b0, 2'd0, exp_ir));
    push(1'b0, 1'b0, 1'b0, 7'd19, o_wb(2'd0, exp_ir));
    exp_ir++;
    push(1'b0, 1'b0, 1'b0, 7'd19, o_fetch(1'b0, exp_ir));
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL rstmid cyc%0d: got state=%0d vec=%h want state=%0d vec=%h", n, obs.state, obs, want.state, want);
      end
      n++;
    end
    $display("rst mid-store: restart done, expect instret=%0d", exp_ir);
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_back_to_back();
    test_decode_traps();
    test_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t reached limit=100000 without finishing", $time);
    $fatal(1);
  end

endmodule
